// File: rtl/vga_frame_timer.sv
// VGA frame timer: 640x480@60 counters, syncs and pixel strobe, plus a
// screen-code register that only changes on a frame boundary.
module vga_frame_timer #(
    parameter int          CLK_DIV      = 4,
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic [3:0]  RESET_SCREEN = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_req,
    input  logic [3:0] sel_next,
    output logic       sel_ack,
    output logic [3:0] screen,
    output logic       pix_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             pix_tick_q, pix_tick_d;
    logic             frame_start_q, frame_start_d;
    logic [3:0]       pend_code_q, pend_code_d;
    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       screen_q, screen_d;
    logic             sel_ack_q, sel_ack_d;

    logic adv;
    logic h_wrap;
    logic boundary;

    always_comb begin
        adv      = (div_q == DIV_LAST);
        h_wrap   = adv && (hcount_q == H_LAST);
        boundary = h_wrap && (vcount_q == V_LAST);

        div_d    = adv ? '0 : div_q + 1'b1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (adv) begin
            hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
        end
        if (h_wrap) begin
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end

        // Decode from next counts so registered flags line up with the counters
        hsync_d  = !((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST));
        vsync_d  = !((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST));
        active_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);

        pix_tick_d    = adv;
        frame_start_d = boundary;

        pend_code_d  = pend_code_q;
        pend_valid_d = pend_valid_q;
        screen_d     = screen_q;
        sel_ack_d    = 1'b0;

        // A live request at the boundary beats the stored one
        if (boundary && (pend_valid_q || sel_req)) begin
            screen_d     = sel_req ? sel_next : pend_code_q;
            sel_ack_d    = 1'b1;
            pend_valid_d = 1'b0;
        end else if (sel_req && !sel_ack_q) begin
            pend_code_d  = sel_next;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            pend_code_q   <= 4'd0;
            pend_valid_q  <= 1'b0;
            screen_q      <= RESET_SCREEN;
            sel_ack_q     <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
            pend_code_q   <= pend_code_d;
            pend_valid_q  <= pend_valid_d;
            screen_q      <= screen_d;
            sel_ack_q     <= sel_ack_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign pix_tick    = pix_tick_q;
    assign frame_start = frame_start_q;
    assign screen      = screen_q;
    assign sel_ack     = sel_ack_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer on a shrunken raster so whole frames fit in
// a short run; expectations come from elapsed-cycle arithmetic.
module tb_vga_frame_timer;

    localparam int D     = 4;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 4;
    localparam int HBP   = 3;
    localparam int VA    = 10;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = D * HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_req = 1'b0;
    logic [3:0] sel_next = 4'd0;
    logic       sel_ack;
    logic [3:0] screen;
    logic       pix_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    vga_frame_timer #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RESET_SCREEN(4'b1111)
    ) dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .sel_next(sel_next),
        .sel_ack(sel_ack), .screen(screen), .pix_tick(pix_tick),
        .hcount(hcount), .vcount(vcount), .active(active),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    // Screen handshake reference state
    logic [3:0] m_scr  = 4'b1111;
    logic [3:0] m_pend = 4'd0;
    logic       m_pv   = 1'b0;
    logic       m_ack  = 1'b0;

    function automatic int ph();      return k / D; endfunction
    function automatic int eh();      return ph() % HT; endfunction
    function automatic int ev();      return (ph() / HT) % VT; endfunction
    function automatic logic ehs();
        return !(eh() >= HA + HFP && eh() < HA + HFP + HS);
    endfunction
    function automatic logic evs();
        return !(ev() >= VA + VFP && ev() < VA + VFP + VS);
    endfunction
    function automatic logic eact();  return eh() < HA && ev() < VA; endfunction
    function automatic logic epix();  return k > 0 && k % D == 0; endfunction
    function automatic logic efs();   return epix() && ph() % (HT * VT) == 0; endfunction

    // One clock: update the handshake model for this edge, then advance.
    task automatic tick();
        logic bnd;
        logic ack_n;
        bnd   = !rst && ((k + 1) % FRAME == 0);
        ack_n = 1'b0;
        if (rst) begin
            m_scr = 4'b1111;
            m_pv  = 1'b0;
        end else if (bnd && (m_pv || sel_req)) begin
            m_scr = sel_req ? sel_next : m_pend;
            ack_n = 1'b1;
            m_pv  = 1'b0;
        end else if (sel_req && !m_ack) begin
            m_pend = sel_next;
            m_pv   = 1'b1;
        end
        m_ack = ack_n;
        @(posedge clk);
        k = rst ? 0 : k + 1;
        @(negedge clk);
    endtask

    task automatic goto_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(eh() == h && ev() == v && k % D == 1) && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (hcount !== 10'd0 || vcount !== 10'd0 || hsync !== 1'b1 ||
                vsync !== 1'b1 || active !== 1'b1 || screen !== 4'b1111 ||
                pix_tick !== 1'b0 || frame_start !== 1'b0 || sel_ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: h=%0d v=%0d hs=%b vs=%b act=%b scr=%h pt=%b fs=%b ack=%b",
                         hcount, vcount, hsync, vsync, active, screen,
                         pix_tick, frame_start, sel_ack);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (pix_tick !== (i == 4) || hcount !== ((i == 4) ? 10'd1 : 10'd0) ||
                vcount !== 10'd0 || screen !== 4'b1111) begin
                bad++;
                $display("FAIL reset_release c%0d: pt=%b h=%0d v=%0d scr=%h",
                         i, pix_tick, hcount, vcount, screen);
            end
        end
    endtask

    task automatic test_line_timing();
        int lows;
        int ph_prev, pv_prev, pa_prev;
        lows = 0;
        ph_prev = hcount; pv_prev = vcount; pa_prev = active;
        for (int i = 0; i < 2 * HT * D; i++) begin
            tick();
            total++;
            if (hcount !== 10'(eh()) || vcount !== 10'(ev()) || hsync !== ehs() ||
                active !== eact() || pix_tick !== epix()) begin
                bad++;
                $display("FAIL line k=%0d: h=%0d/%0d v=%0d/%0d hs=%b/%b act=%b/%b pt=%b/%b",
                         k, hcount, eh(), vcount, ev(), hsync, ehs(),
                         active, eact(), pix_tick, epix());
            end
            if (ph_prev == HT - 1 && hcount == 0) begin
                total++;
                if (vcount !== 10'((pv_prev + 1) % VT)) begin
                    bad++;
                    $display("FAIL line_vinc: v=%0d want %0d", vcount, (pv_prev + 1) % VT);
                end
            end
            if (pa_prev == 1 && active == 1'b0) begin
                total++;
                if (hcount !== 10'(HA)) begin
                    bad++;
                    $display("FAIL active_fall: h=%0d want %0d", hcount, HA);
                end
            end
            if (hsync == 1'b0) lows++;
            ph_prev = hcount; pv_prev = vcount; pa_prev = active;
        end
        total++;
        if (lows != 2 * HS * D) begin
            bad++;
            $display("FAIL hsync_low_clk: got %0d want %0d", lows, 2 * HS * D);
        end
    endtask

    task automatic test_frame_timing();
        int lows, last_fs, nfs;
        lows = 0; last_fs = -1; nfs = 0;
        for (int i = 0; i < 2 * FRAME + D; i++) begin
            tick();
            total++;
            if (vsync !== evs() || frame_start !== efs() || hcount !== 10'(eh())) begin
                bad++;
                $display("FAIL frame k=%0d: vs=%b/%b fs=%b/%b h=%0d/%0d",
                         k, vsync, evs(), frame_start, efs(), hcount, eh());
            end
            if (i < 2 * FRAME && vsync == 1'b0) lows++;
            if (frame_start === 1'b1) begin
                nfs++;
                total++;
                if (hcount !== 10'd0 || vcount !== 10'd0 || active !== 1'b1) begin
                    bad++;
                    $display("FAIL fs_pos: h=%0d v=%0d act=%b", hcount, vcount, active);
                end
                if (last_fs >= 0) begin
                    total++;
                    if (k - last_fs != FRAME) begin
                        bad++;
                        $display("FAIL fs_spacing: got %0d want %0d", k - last_fs, FRAME);
                    end
                end
                last_fs = k;
            end
        end
        total++;
        if (lows != 2 * VS * HT * D || nfs < 2) begin
            bad++;
            $display("FAIL vsync_low_clk: got %0d want %0d (fs seen %0d)",
                     lows, 2 * VS * HT * D, nfs);
        end
    endtask

    task automatic test_switch();
        logic got;
        got = 1'b0;
        goto_pos(7, 5);
        sel_req = 1'b1;
        sel_next = 4'b0101;
        for (int i = 0; i < FRAME + 8 && !got; i++) begin
            tick();
            total++;
            if (screen !== m_scr || sel_ack !== m_ack) begin
                bad++;
                $display("FAIL switch k=%0d: scr=%h want %h ack=%b want %b",
                         k, screen, m_scr, sel_ack, m_ack);
            end
            if (sel_ack === 1'b1) begin
                got = 1'b1;
                sel_req = 1'b0;
                total++;
                if (frame_start !== 1'b1 || screen !== 4'b0101) begin
                    bad++;
                    $display("FAIL switch_ack: fs=%b scr=%h want 5", frame_start, screen);
                end
            end else if (screen !== 4'b1111) begin
                total++;
                bad++;
                $display("FAIL switch_early: scr=%h want f", screen);
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL switch_timeout: ack=%b want 1", sel_ack);
            sel_req = 1'b0;
        end
        tick();
        total++;
        if (sel_ack !== 1'b0 || screen !== 4'b0101) begin
            bad++;
            $display("FAIL switch_after: ack=%b scr=%h want 0/5", sel_ack, screen);
        end
    endtask

    task automatic test_last_wins();
        logic got;
        got = 1'b0;
        goto_pos($urandom_range(0, HT - 1), $urandom_range(1, VT - 4));
        sel_req = 1'b1;
        sel_next = 4'b0011;
        repeat ($urandom_range(1, 20)) tick();
        sel_next = 4'b0100;
        for (int i = 0; i < FRAME + 8 && !got; i++) begin
            tick();
            if (sel_ack === 1'b1) begin
                got = 1'b1;
                sel_req = 1'b0;
            end
        end
        total++;
        if (!got || screen !== 4'b0100 || m_scr !== 4'b0100) begin
            bad++;
            $display("FAIL last_wins: got=%b scr=%h want 4", got, screen);
            sel_req = 1'b0;
        end
    endtask

    task automatic test_boundary_arrival();
        logic [3:0] code;
        int n;
        n = 0;
        while ((k + 1) % FRAME != 0 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        code = 4'($urandom_range(0, 15));
        sel_req = 1'b1;
        sel_next = code;
        tick();
        sel_req = 1'b0;
        total++;
        if (sel_ack !== 1'b1 || frame_start !== 1'b1 || screen !== code) begin
            bad++;
            $display("FAIL boundary_arrival: ack=%b fs=%b scr=%h want 1/1/%h",
                     sel_ack, frame_start, screen, code);
        end
        tick();
        total++;
        if (sel_ack !== 1'b0 || screen !== code) begin
            bad++;
            $display("FAIL boundary_after: ack=%b scr=%h want 0/%h", sel_ack, screen, code);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            tick();
            total++;
            if (screen !== m_scr || sel_ack !== m_ack || frame_start !== efs() ||
                vcount !== 10'(ev())) begin
                bad++;
                $display("FAIL random k=%0d: scr=%h/%h ack=%b/%b fs=%b/%b v=%0d/%0d",
                         k, screen, m_scr, sel_ack, m_ack, frame_start, efs(),
                         vcount, ev());
            end
            if (!sel_req) begin
                if ($urandom_range(0, 299) == 0) begin
                    sel_req = 1'b1;
                    sel_next = 4'($urandom_range(0, 15));
                end
            end else if (sel_ack || $urandom_range(0, 39) == 0) begin
                sel_req = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                sel_next = 4'($urandom_range(0, 15));
            end
        end
        sel_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen_fs;
        seen_fs = 1'b0;
        goto_pos(12, 9);
        sel_req = 1'b1;
        sel_next = 4'b1010;
        tick();
        sel_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (hcount !== 10'd0 || vcount !== 10'd0 || hsync !== 1'b1 ||
            vsync !== 1'b1 || active !== 1'b1 || screen !== 4'b1111 ||
            pix_tick !== 1'b0 || frame_start !== 1'b0 || sel_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: h=%0d v=%0d hs=%b vs=%b act=%b scr=%h pt=%b fs=%b ack=%b",
                     hcount, vcount, hsync, vsync, active, screen,
                     pix_tick, frame_start, sel_ack);
        end
        for (int i = 0; i < FRAME + 8; i++) begin
            tick();
            if (frame_start === 1'b1) seen_fs = 1'b1;
            total++;
            if (sel_ack !== 1'b0 || screen !== 4'b1111) begin
                bad++;
                $display("FAIL reset_mid_ack k=%0d: ack=%b scr=%h want 0/f",
                         k, sel_ack, screen);
            end
        end
        total++;
        if (!seen_fs) begin
            bad++;
            $display("FAIL reset_mid_fs: frame_start=0 want 1");
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_switch();
        test_last_wins();
        test_boundary_arrival();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
